mips_multicycle: RTL
====================

# mips_multicycle

Parametrised multi-cycle successor to the single-cycle 16-bit core: one FSM sequences fetch, decode, execute, memory and write-back, sharing one ALU. Data width and PC width are generic; 16-bit instruction format is fixed. Instruction and data memories sit behind req/ready handshakes, so variable-latency memories and caches plug in without changing the core.

## Interface
Parameters:
- DATA_W, 16, register/ALU/data-memory width; ≥ 8.
- ADDR_W, 8, PC and data-address width; ≤ 11.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  out  ADDR_W  current PC; also the instruction fetch address.
- imem_req  out  1  fetch request.
- imem_ready  in  1  fetch complete; instr valid this cycle.
- instr  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  ADDR_W  low ADDR_W bits of ALU result.
- dmem_wdata  out  DATA_W  store data.
- dmem_ready  in  1  access complete; load data valid this cycle.
- dmem_rdata  in  DATA_W  load data.
- flags  out  3  {C,N,Z}.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core in HALT.

## Operation
- Fields: op=[15:11], rd=[10:8], rs=[7:5], rt=[4:2], imm5=[4:0] (sign-extended), imm8=[7:0] (zero-extended), jaddr=[ADDR_W-1:0].
- 8 registers; r0 reads 0, writes to it are dropped.
- Opcodes: 00000 NOP; 00001 ADD; 00010 SUB; 00011 AND; 00100 OR; 00101 XOR. These compute rd=rs op rt.
- 00110 SLL and 00111 SRL: rd=rs shifted by imm5[3:0].
- 01000 ADDI: rd=rs+imm5. 01001 LDI: rd=imm8.
- 01010 LW: rd=mem[rs+imm5]. 01011 SW: mem[rs+imm5]=rd.
- 01100 BEQ / 01101 BNE: compare rd with rs; if taken, pc = pc_of_branch+1+imm5.
- 01110 JMP: pc=jaddr. 11111 HALT. All other opcodes execute as NOP.
- Arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^ADDR_W.
- Flags are updated at WB by ADD/SUB/AND/OR/XOR/SLL/SRL/ADDI only.
  - Z = result==0. N = result MSB.
  - C = carry-out (ADD/ADDI) or no-borrow, i.e. rs≥rt unsigned (SUB). Logic and shift ops clear C.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1. On imem_ready, latch IR, pc←pc+1, go to DECODE.
  - DECODE: latch A=R[rs], B=R[rt], or R[rd] for SW/BEQ/BNE. Go to EXEC.
  - EXEC: ALU ops, ADDI and LDI go to WB. LW/SW go to MEM. Branch/JMP update pc, pulse retire, go to FETCH. NOP pulses retire, goes to FETCH. HALT goes to HALT.
  - MEM: dmem_req=1. On dmem_ready, LW latches data and goes to WB; SW pulses retire and goes to FETCH.
  - WB: write rd, update flags, pulse retire, go to FETCH.
  - HALT: terminal; halted=1. Only reset leaves it.

## Timing
- Reset (reset=0 at a clock edge): state=FETCH, pc=0, all registers=0, flags=0, imem_req=dmem_req=0 in the following cycle, retire=0, halted=0.
- Reset in any state, including mid-handshake, abandons the transaction. imem_req rises again on the first cycle after reset is released.
- Handshake:
  - req is asserted from the state's first cycle.
  - Address, we and wdata stay stable until the cycle ready is sampled high; ready in the same cycle as req is legal (zero-wait).
  - req drops in the cycle after completion.
  - ready is ignored while req=0.
- Zero-wait cycle counts: ALU/ADDI/LDI/SW take 4 cycles, LW 5, branch/JMP/NOP 3. Each memory wait cycle adds 1.
- pc visible change:
  - pc+1 the cycle after fetch completes.
  - Branch/JMP target the cycle after EXEC.
- retire is high exactly one cycle per instruction and never in HALT.

## Structure
- Package mips_mc_pkg: opcode localparams, state enum, flag bit indices (Z=0, N=1, C=2).
- Sub-module mips_regfile: 8×DATA_W, two combinational read ports, one synchronous write port, r0 hardwired to 0.
- ALU, FSM and datapath registers (IR, A, B, ALUOut, MDR) live in the top.

## Test plan
- Reset/fetch: hold reset=0 for 3 cycles, then release with imem_ready tied 1 → pc=0, imem_req=1 on the first released cycle, pc=1 two cycles later.
- ALU and flags:
  - Program LDI r1,0xFF; LDI r2,0x01; ADD r3,r1,r2 (DATA_W=8) → r3=0x00, flags Z=1, C=1, N=0.
  - A following SUB r4,r2,r1 → r4=0x02, C=0.
- Memory with waits: SW r3→[r0+4], then LW r5,[r0+4], dmem_ready delayed 3 cycles each → dmem_addr=4 held stable while waiting, r5 equals r3, SW takes 7 cycles and LW 8.
- Branch wrap: ADDR_W=8, BEQ r0,r0,-2 at pc=0x00 → next fetch pc=0xFF. BNE with equal operands → pc=0x01, taken in 3 cycles.
- HALT and illegal ops: opcode 10101 → behaves as NOP, retire pulses. Then HALT → halted=1, no further imem_req, retire stays 0 for 20 cycles.
- Reset mid-MEM: assert reset while dmem_req=1 and dmem_ready=0 → next cycle dmem_req=0, pc=0, registers cleared.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle 16-bit-instruction core.
// Covers opcodes, FSM states, flag bit positions and opcode-class helpers.
package mips_mc_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned FLAGS_W   = 3;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  localparam logic [OP_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00011;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b01001;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01010;
  localparam logic [OP_W-1:0] OP_SW   = 5'b01011;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'b01100;
  localparam logic [OP_W-1:0] OP_BNE  = 5'b01101;
  localparam logic [OP_W-1:0] OP_JMP  = 5'b01110;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  // Ops whose ALU result is written to rd through WB
  function automatic logic op_is_alu_wb(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                      OP_SLL, OP_SRL, OP_ADDI, OP_LDI};
  endfunction

  function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                      OP_SLL, OP_SRL, OP_ADDI};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous write.
// Entry 0 always reads as zero and ignores writes.
module mips_regfile
  import mips_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0]    ra_data_o,
  input  logic [REG_IDX_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0]    rb_data_o,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0]    wa_data_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (we_i && (wa_addr_i != '0)) begin
      regs_q[wa_addr_i] <= wa_data_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over a shared ALU.
// Instruction and data memories are reached through req/ready handshakes.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  pc,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [FLAGS_W-1:0] flags,
  output logic               retire,
  output logic               halted
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  a_q, b_q, aluout_q, mdr_q;
  logic               carry_q;
  logic [FLAGS_W-1:0] flags_q, flags_new;
  logic               imem_req_q, dmem_req_q, dmem_we_q, retire_q, halted_q;
  logic               imem_req_d, dmem_req_d, dmem_we_d, retire_d, halted_d;
  logic               ld_ir, ld_ab, ld_alu, ld_mdr, rf_we, fl_we;

  // Instruction fields
  logic [OP_W-1:0]      op;
  logic [REG_IDX_W-1:0] rd_idx, rs_idx, rt_idx, rb_idx;
  logic [DATA_W-1:0]    imm5_sx, imm8_zx;
  logic [ADDR_W-1:0]    br_off, jaddr;
  logic [3:0]           shamt;

  assign op      = ir_q[15:11];
  assign rd_idx  = ir_q[10:8];
  assign rs_idx  = ir_q[7:5];
  assign rt_idx  = ir_q[4:2];
  assign imm5_sx = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign imm8_zx = DATA_W'(ir_q[7:0]);
  assign br_off  = {{(ADDR_W-5){ir_q[4]}}, ir_q[4:0]};
  assign jaddr   = ir_q[ADDR_W-1:0];
  assign shamt   = ir_q[3:0];

  logic imem_done, dmem_done;
  assign imem_done = imem_req_q && imem_ready;
  assign dmem_done = dmem_req_q && dmem_ready;

  // Store and compare ops take their second operand from rd
  assign rb_idx = (op == OP_SW || op == OP_BEQ || op == OP_BNE) ? rd_idx : rt_idx;

  logic [DATA_W-1:0] ra_data, rb_data, wb_data;
  assign wb_data = (op == OP_LW) ? mdr_q : aluout_q;

  mips_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (rs_idx),
    .ra_data_o (ra_data),
    .rb_addr_i (rb_idx),
    .rb_data_o (rb_data),
    .we_i      (rf_we),
    .wa_addr_i (rd_idx),
    .wa_data_i (wb_data)
  );

  // Shared ALU; alu_c is carry-out for adds, no-borrow for SUB, 0 otherwise
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic [DATA_W:0]   sum;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    sum   = '0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_ADDI: begin
        sum   = {1'b0, a_q} + {1'b0, imm5_sx};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      OP_SUB: begin
        alu_y = a_q - b_q;
        alu_c = (a_q >= b_q);
      end
      OP_AND:        alu_y = a_q & b_q;
      OP_OR:         alu_y = a_q | b_q;
      OP_XOR:        alu_y = a_q ^ b_q;
      OP_SLL:        alu_y = a_q << shamt;
      OP_SRL:        alu_y = a_q >> shamt;
      OP_LDI:        alu_y = imm8_zx;
      OP_LW, OP_SW:  alu_y = a_q + imm5_sx;
      default:       alu_y = '0;
    endcase
  end

  logic br_taken;
  assign br_taken = ((op == OP_BEQ) && (a_q == b_q)) ||
                    ((op == OP_BNE) && (a_q != b_q));

  always_comb begin
    flags_new         = '0;
    flags_new[FLAG_Z] = (aluout_q == '0);
    flags_new[FLAG_N] = aluout_q[DATA_W-1];
    flags_new[FLAG_C] = carry_q;
  end

  // FSM state register and registered control outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_done) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW:                    state_d = S_MEM;
          OP_HALT:                         state_d = S_HALT;
          OP_NOP, OP_BEQ, OP_BNE, OP_JMP:  state_d = S_FETCH;
          default: state_d = op_is_alu_wb(op) ? S_WB : S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_done) state_d = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output/control logic; requests are registered so they rise with the state
  always_comb begin
    pc_d   = pc_q;
    ld_ir  = 1'b0;
    ld_ab  = 1'b0;
    ld_alu = 1'b0;
    ld_mdr = 1'b0;
    rf_we  = 1'b0;
    fl_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_done) begin
          ld_ir = 1'b1;
          pc_d  = pc_q + ADDR_W'(1);
        end
      end
      S_DECODE: ld_ab = 1'b1;
      S_EXEC: begin
        ld_alu = 1'b1;
        if (op == OP_JMP)  pc_d = jaddr;
        else if (br_taken) pc_d = pc_q + br_off;
      end
      S_MEM: ld_mdr = dmem_done;
      S_WB: begin
        rf_we = 1'b1;
        fl_we = op_sets_flags(op);
      end
      default: ;
    endcase
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (op == OP_SW);
    halted_d   = (state_d == S_HALT);
    // Every completed instruction returns to FETCH exactly once
    retire_d   = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      carry_q  <= 1'b0;
      mdr_q    <= '0;
      flags_q  <= '0;
    end else begin
      if (ld_ir) ir_q <= instr;
      if (ld_ab) begin
        a_q <= ra_data;
        b_q <= rb_data;
      end
      if (ld_alu) begin
        aluout_q <= alu_y;
        carry_q  <= alu_c;
      end
      if (ld_mdr) mdr_q <= dmem_rdata;
      if (fl_we)  flags_q <= flags_new;
    end
  end

  assign pc         = pc_q;
  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = ADDR_W'(aluout_q);
  assign dmem_wdata = b_q;
  assign flags      = flags_q;
  assign retire     = retire_q;
  assign halted     = halted_q;

endmodule
